// File: rtl/prim_pkg.sv
// Shared types and constants for the operand-gate primitives.
package prim_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_e;

    localparam string IMPL_AND = "AND";
    localparam string IMPL_MUX = "MUX";

endpackage

// File: rtl/prim_opgate.sv
// Operand gate: forces data_o to zero while en_i is low, as an AND mask or a 2:1 mux.
module prim_opgate
    import prim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter string       IMPLEMENTATION = "AND"
) (
    input  logic                  en_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    if (IMPLEMENTATION == IMPL_AND) begin : g_and
        assign data_o = data_i & {DATA_WIDTH{en_i}};
    end else if (IMPLEMENTATION == IMPL_MUX) begin : g_mux
        assign data_o = en_i ? data_i : '0;
    end else begin : g_bad
        $error("prim_opgate: IMPLEMENTATION must be \"AND\" or \"MUX\"");
        assign data_o = '0;
    end

endmodule

// File: rtl/prim_opgate_skid.sv
// Two-entry skid buffer feeding a gated operand output with a post-transfer hold window.
// Optional PRIM_OPGATE_SKID_ZERO_EN clears vacated main/skid registers.
//
// state      | meaning
// SKID_EMPTY | no operand buffered
// SKID_ONE   | main holds the head operand
// SKID_FULL  | main holds the head, skid holds the next operand
module prim_opgate_skid
    import prim_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned HOLD_CYCLES    = 2,
    parameter string       IMPLEMENTATION = "AND"
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [DATA_WIDTH-1:0] in_data_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic                  gate_en_o
);

    // A zero-cycle hold still needs a one-bit counter to keep widths legal.
    localparam int unsigned CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] HOLD_VAL = CNT_W'(HOLD_CYCLES);

    skid_state_e           state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  push, pop;

    assign out_valid_o = (state_q != SKID_EMPTY);
    assign in_ready_o  = (state_q != SKID_FULL);
    assign push        = in_valid_i & in_ready_o;
    assign pop         = out_valid_o & out_ready_i;
    assign gate_en_o   = out_valid_o | (cnt_q != '0);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= SKID_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            SKID_EMPTY: begin
                if (push) begin
                    state_d = SKID_ONE;
                    main_d  = in_data_i;
                end
            end
            SKID_ONE: begin
                if (push && pop) begin
                    main_d = in_data_i;
                end else if (push) begin
                    state_d = SKID_FULL;
                    skid_d  = in_data_i;
                end else if (pop) begin
                    state_d = SKID_EMPTY;
`ifdef PRIM_OPGATE_SKID_ZERO_EN
                    main_d  = '0;
`endif
                end
            end
            SKID_FULL: begin
                if (pop) begin
                    state_d = SKID_ONE;
                    main_d  = skid_q;
`ifdef PRIM_OPGATE_SKID_ZERO_EN
                    skid_d  = '0;
`endif
                end
            end
            default: state_d = SKID_EMPTY;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (pop) begin
            cnt_d = HOLD_VAL;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    prim_opgate #(
        .DATA_WIDTH     (DATA_WIDTH),
        .IMPLEMENTATION (IMPLEMENTATION)
    ) u_opgate (
        .en_i   (gate_en_o),
        .data_i (main_q),
        .data_o (out_data_o)
    );

endmodule

// File: tb/tb_prim_opgate_skid.sv
// Self-checking bench: a default instance and a HOLD_CYCLES=0 / MUX instance driven in lockstep.
module tb_prim_opgate_skid;

`ifdef PRIM_OPGATE_SKID_ZERO_EN
    localparam bit ZERO = 1'b1;
`else
    localparam bit ZERO = 1'b0;
`endif

    typedef struct {
        bit          rst_n;
        bit          iv;
        logic [31:0] d;
        bit          ordy;
        bit          ev;
        bit          er;
        bit          eg;
        logic [31:0] ed;
    } row_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;

    logic        a_in_ready, a_out_valid, a_gate;
    logic [31:0] a_out_data;
    logic        b_in_ready, b_out_valid, b_gate;
    logic [31:0] b_out_data;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] qa[$];
    logic [31:0] qb[$];
    row_t        vec[$];

    always #5 clk = ~clk;

    prim_opgate_skid #(.DATA_WIDTH(32), .HOLD_CYCLES(2), .IMPLEMENTATION("AND")) dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(a_in_ready), .in_data_i(in_data),
        .out_valid_o(a_out_valid), .out_ready_i(out_ready), .out_data_o(a_out_data),
        .gate_en_o(a_gate)
    );

    prim_opgate_skid #(.DATA_WIDTH(32), .HOLD_CYCLES(0), .IMPLEMENTATION("MUX")) dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .in_valid_i(in_valid), .in_ready_o(b_in_ready), .in_data_i(in_data),
        .out_valid_o(b_out_valid), .out_ready_i(out_ready), .out_data_o(b_out_data),
        .gate_en_o(b_gate)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void add(input bit r, input bit iv, input logic [31:0] d, input bit ordy,
                                input bit ev, input bit er, input bit eg, input logic [31:0] ed);
        row_t t;
        t.rst_n = r; t.iv = iv; t.d = d; t.ordy = ordy;
        t.ev = ev; t.er = er; t.eg = eg; t.ed = ed;
        vec.push_back(t);
    endfunction

    // Scoreboard: operands enter on an observed push, are checked on an observed pop.
    always @(negedge clk) begin
        if (!rst_n) begin
            qa.delete();
            qb.delete();
        end else begin
            if (a_out_valid && out_ready) begin
                if (qa.size() == 0) chk("sb_a_underflow", a_out_data, 32'hFFFF_FFFF);
                else chk("sb_a_data", a_out_data, qa.pop_front());
            end
            if (b_out_valid && out_ready) begin
                if (qb.size() == 0) chk("sb_b_underflow", b_out_data, 32'hFFFF_FFFF);
                else chk("sb_b_data", b_out_data, qb.pop_front());
            end
            if (in_valid && a_in_ready) qa.push_back(in_data);
            if (in_valid && b_in_ready) qb.push_back(in_data);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] stale;
        // reset with junk inputs
        add(0, 1, 32'hDEAD_BEEF, 1, 0, 1, 0, 0);
        add(0, 1, 32'hDEAD_BEEF, 1, 0, 1, 0, 0);
        // streaming 1..8
        for (int k = 1; k <= 8; k++) add(1, 1, k, 1, 1, 1, 1, k);
        // drain, then hold window of two cycles
        stale = ZERO ? 32'h0 : 32'h8;
        add(1, 0, 0, 1, 0, 1, 1, stale);
        add(1, 0, 0, 1, 0, 1, 1, stale);
        add(1, 0, 0, 1, 0, 1, 0, 0);
        // backpressure
        add(1, 1, 32'hA, 0, 1, 1, 1, 32'hA);
        add(1, 1, 32'hB, 0, 1, 0, 1, 32'hA);
        add(1, 1, 32'hC, 0, 1, 0, 1, 32'hA);
        add(1, 1, 32'hC, 1, 1, 1, 1, 32'hB);
        add(1, 1, 32'hC, 1, 1, 1, 1, 32'hC);
        stale = ZERO ? 32'h0 : 32'hC;
        add(1, 0, 0, 1, 0, 1, 1, stale);
        add(1, 0, 0, 1, 0, 1, 1, stale);
        add(1, 0, 0, 1, 0, 1, 0, 0);
        // reset while FULL
        add(1, 1, 32'hA, 0, 1, 1, 1, 32'hA);
        add(1, 1, 32'hB, 0, 1, 0, 1, 32'hA);
        add(0, 1, 32'hEE, 1, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 1, 0, 0);
        add(1, 0, 0, 1, 0, 1, 0, 0);
        // single 0xFF drained
        add(1, 1, 32'hFF, 0, 1, 1, 1, 32'hFF);
        add(1, 0, 0, 1, 0, 1, 1, ZERO ? 32'h0 : 32'hFF);

        for (int i = 0; i < vec.size(); i++) begin
            rst_n     = vec[i].rst_n;
            in_valid  = vec[i].iv;
            in_data   = vec[i].d;
            out_ready = vec[i].ordy;
            @(posedge clk);
            #1;
            chk("a_out_valid", 32'(a_out_valid), 32'(vec[i].ev));
            chk("a_in_ready",  32'(a_in_ready),  32'(vec[i].er));
            chk("a_gate_en",   32'(a_gate),      32'(vec[i].eg));
            chk("a_out_data",  a_out_data,       vec[i].ed);
            chk("b_out_valid", 32'(b_out_valid), 32'(vec[i].ev));
            chk("b_in_ready",  32'(b_in_ready),  32'(vec[i].er));
            chk("b_gate_en",   32'(b_gate),      32'(vec[i].ev));
            chk("b_out_data",  b_out_data,       vec[i].ev ? vec[i].ed : 32'h0);
        end

        chk("a_main_after_drain", dut_a.main_q, ZERO ? 32'h0 : 32'hFF);
        chk("b_main_after_drain", dut_b.main_q, ZERO ? 32'h0 : 32'hFF);

        in_valid  = 1'b0;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        chk("a_queue_empty", 32'(qa.size()), 32'h0);
        chk("b_queue_empty", 32'(qb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
